// File: rtl/osd_digit_ctrl.sv
// osd_digit_ctrl: converts a signed value into four BCD digits plus a sign flag
// for an on-screen digit window. The conversion runs in the background on
// shadow registers. The displayed digits change all at once, either as soon as
// the conversion finishes or at the next frame boundary.
module osd_digit_ctrl #(
  parameter int SAT_MAX = 9999,
  parameter int NBITS   = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [14:0] val_in,
  input  logic        val_valid,
  output logic        val_ready,
  input  logic        upd_immediate,
  output logic        znak,
  output logic [3:0]  cifra_XXXX,
  output logic [3:0]  cifra_XXX,
  output logic [3:0]  cifra_XX,
  output logic [3:0]  cifra_X,
  output logic        busy
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ABS  = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam logic [1:0] S_PEND = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [14:0]      val_q, val_d;
  logic             sign_q, sign_d;
  logic [NBITS-1:0] mag_q, mag_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vs_q;
  logic             znak_q, znak_d;
  logic [15:0]      disp_q, disp_d;

  logic        frame_rise;
  logic [15:0] abs_val;
  logic [15:0] sat_val;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;

  // The frame boundary is the first cycle in which vsync is seen high.
  assign frame_rise = vsync & ~vs_q;

  // Magnitude of the captured value. The sign-extended 16-bit negate keeps
  // -16384 representable as +16384 before it is clamped.
  always_comb begin
    abs_val = val_q[14] ? (16'd0 - {1'b1, val_q}) : {1'b0, val_q};
    sat_val = (abs_val > 16'(SAT_MAX)) ? 16'(SAT_MAX) : abs_val;
  end

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    always_comb begin
      bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                      : bcd_q[4*gi +: 4];
    end
  end

  // One double-dabble step: shift the next magnitude bit into the corrected BCD value.
  assign bcd_shift = {bcd_adj[14:0], mag_q[NBITS-1]};

  // Next-state logic for the control FSM, the shadow registers and the display registers.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    znak_d  = znak_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (val_valid) begin
          val_d   = val_in;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        sign_d  = val_q[14] && (val_q != 15'd0);
        mag_d   = sat_val[NBITS-1:0];
        bcd_d   = 16'd0;
        cnt_d   = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        bcd_d = bcd_shift;
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NBITS - 1)) begin
          cnt_d = '0;
          if (upd_immediate) begin
            // The final shift result goes straight to the display.
            disp_d  = bcd_shift;
            znak_d  = sign_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (frame_rise) begin
          disp_d  = bcd_q;
          znak_d  = sign_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset drops any value that is being converted or is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      vs_q    <= 1'b0;
      znak_q  <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      vs_q    <= vsync;
      znak_q  <= znak_d;
      disp_q  <= disp_d;
    end
  end

  assign val_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign znak       = znak_q;
  assign cifra_XXXX = disp_q[15:12];
  assign cifra_XXX  = disp_q[11:8];
  assign cifra_XX   = disp_q[7:4];
  assign cifra_X    = disp_q[3:0];

endmodule

// File: tb/tb_osd_digit_ctrl.sv
// Testbench for osd_digit_ctrl. A driver issues directed and random values.
// For each value it pushes the expected display word and commit edge into a
// queue. A negedge monitor pops an entry when busy falls and compares it. On
// every other cycle the monitor checks that the display holds its last value.
module tb_osd_digit_ctrl;
  localparam int NB = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic [14:0] val_in = '0;
  logic        val_valid = 1'b0;
  logic        upd_immediate = 1'b0;
  logic        val_ready, znak, busy;
  logic [3:0]  c3, c2, c1, c0;

  always #5 clk = ~clk;

  osd_digit_ctrl #(.SAT_MAX(9999), .NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .val_in(val_in),
    .val_valid(val_valid), .val_ready(val_ready), .upd_immediate(upd_immediate),
    .znak(znak), .cifra_XXXX(c3), .cifra_XXX(c2), .cifra_XX(c1), .cifra_X(c0),
    .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [16:0] val;
    int          at;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [16:0] shown = '0;
  logic [16:0] dut_word;
  logic        prev_busy = 1'b0;

  // Reference: sign flag plus four decimal digits of the clamped magnitude.
  function automatic logic [16:0] model(input logic [14:0] v);
    int x, m;
    bit sg;
    x  = $signed(v);
    sg = (x < 0);
    m  = sg ? -x : x;
    if (m > 9999) m = 9999;
    return {sg, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // Monitor: checks each commit against the scoreboard and checks that the display holds otherwise.
  always @(negedge clk) begin
    dut_word = {znak, c3, c2, c1, c0};
    if (!rst_n) begin
      prev_busy = 1'b0;
      shown     = '0;
    end else begin
      if (prev_busy && !busy) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL spurious_commit edge %0d: got %h required no commit", cyc, dut_word);
        end else begin
          mon_e = q.pop_front();
          if (dut_word !== mon_e.val || cyc != mon_e.at) begin
            bad++;
            $display("FAIL commit: got %h at edge %0d required %h at edge %0d",
                     dut_word, cyc, mon_e.val, mon_e.at);
          end else begin
            $display("commit %h at edge %0d", dut_word, cyc);
          end
          shown = mon_e.val;
        end
      end else begin
        total++;
        if (dut_word !== shown) begin
          bad++;
          $display("FAIL hold edge %0d: got %h required %h", cyc, dut_word, shown);
        end
      end
      if (q.size() > 0 && cyc > q[0].at + 2) begin
        total++;
        bad++;
        $display("FAIL timeout: no commit by edge %0d, required %h at edge %0d",
                 cyc, q[0].val, q[0].at);
        void'(q.pop_front());
      end
      prev_busy = busy;
    end
  end

  task automatic drive_idle_cycle();
    val_valid     = 1'b0;
    val_in        = 15'($urandom);
    upd_immediate = 1'($urandom_range(0, 1));
    vsync         = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  // Issue one value. off<0 picks a random frame delay. rst_iter>=0 pulses reset
  // before that CONV iteration, and no expected entry is pushed.
  task automatic send(input logic [14:0] v, input bit imm, input int off, input int rst_iter);
    int   e0, f, e, last;
    exp_t ex;
    repeat ($urandom_range(0, 3)) drive_idle_cycle();
    e0   = cyc + 1;
    f    = e0 + NB + 2 + ((off < 0) ? int'($urandom_range(0, 30)) : off);
    last = imm ? e0 + NB + 1 : f;
    val_valid     = 1'b1;
    val_in        = v;
    upd_immediate = 1'($urandom_range(0, 1));
    vsync         = 1'($urandom_range(0, 1));
    if (rst_iter < 0) begin
      ex.val = model(v);
      ex.at  = last;
      q.push_back(ex);
      $display("send val=%0d imm=%0d expect %h at edge %0d", $signed(v), imm, ex.val, last);
    end else begin
      $display("send val=%0d with reset before iteration %0d", $signed(v), rst_iter);
    end
    @(negedge clk);
    while (cyc < last) begin
      e = cyc + 1;
      if (rst_iter >= 0 && e == e0 + 2 + rst_iter) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {15'd0, znak, c3, c2, c1, c0}, 32'd0);
        chk("rst_mid_ready", {31'd0, val_ready}, 32'd1);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        val_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      val_valid     = 1'($urandom_range(0, 1));
      val_in        = 15'($urandom);
      upd_immediate = (e == e0 + NB + 1) ? imm : 1'($urandom_range(0, 1));
      if (imm)                  vsync = 1'($urandom_range(0, 1));
      else if (e == f)          vsync = 1'b1;
      else if (e >= e0 + NB + 1) vsync = 1'b0;
      else                      vsync = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [14:0] rv;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {15'd0, znak, c3, c2, c1, c0}, 32'd0);
    chk("reset_ready", {31'd0, val_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    send(15'd1234, 1'b1, 0, -1);
    send(15'(-507), 1'b0, 24, -1);
    send(15'd12000, 1'b1, 0, -1);
    send(15'h4000, 1'b0, -1, -1);
    send(15'd0, 1'b0, -1, -1);
    send(15'd9999, 1'b1, 0, -1);
    send(15'(-9999), 1'b0, 0, -1);
    send(15'(-1), 1'b1, 0, -1);
    send(15'd4321, 1'b0, -1, 7);
    send(15'd42, 1'b1, 0, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       rv = 15'($urandom);
        1:       rv = 15'($urandom_range(0, 9999));
        default: rv = 15'(-int'($urandom_range(0, 10000)));
      endcase
      send(rv, 1'($urandom_range(0, 1)), -1, -1);
    end

    repeat (5) drive_idle_cycle();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/osd_digit_ctrl.md
OSD_DIGIT_CTRL -- requirements
Module: osd_digit_ctrl

Interface
REQ-001 Parameter: SAT_MAX, default 9999, largest displayable magnitude; larger magnitudes are clamped to it.
REQ-002 Parameter: NBITS, default 14, magnitude width and number of conversion iterations.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: vsync  input  1  frame sync level; its rising edge marks a frame boundary.
REQ-006 Port: val_in  input  15  signed two's-complement value to display.
REQ-007 Port: val_valid  input  1  val_in is valid.
REQ-008 Port: val_ready  output  1  block accepts a value.
REQ-009 Port: upd_immediate  input  1  1 = skip the frame wait; 0 = commit only on a frame boundary.
REQ-010 Port: znak  output  1  minus-sign flag to the digit window.
REQ-011 Port: cifra_XXXX  output  4  BCD thousands digit.
REQ-012 Port: cifra_XXX  output  4  BCD hundreds digit.
REQ-013 Port: cifra_XX  output  4  BCD tens digit.
REQ-014 Port: cifra_X  output  4  BCD units digit.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ABS, CONV and PEND.
REQ-017 val_ready SHALL equal (state==IDLE), decoded combinationally.
REQ-018 IDLE: on val_valid&&val_ready the block SHALL capture val_in and go to ABS.
REQ-019 ABS, one cycle: sign = val_in[14]&&(val_in!=0); mag = |val_in|; mag>SAT_MAX clamps to SAT_MAX; -16384 clamps to 9999 with sign=1; the block SHALL then go to CONV.
REQ-020 CONV, exactly NBITS cycles:
- conversion is shift-add-3 (double dabble) on a 16-bit BCD shadow register;
- one shift per cycle;
- the add-3 correction applies to each nibble >=5 before the shift;
- an iteration counter runs 0..NBITS-1.
REQ-021 After the last CONV iteration the block SHALL commit in the same cycle if upd_immediate=1 and return to IDLE; otherwise it SHALL go to PEND.
REQ-022 vsync SHALL be registered (vs_d); frame_rise = vsync&&!vs_d.
REQ-023 PEND: on frame_rise the block SHALL commit and go to IDLE; otherwise it SHALL hold with no timeout.
REQ-024 Commit SHALL load znak and cifra_* from the shadow sign and BCD registers simultaneously; the outputs SHALL never show a partial value.
REQ-025 A frame_rise during IDLE, ABS or CONV SHALL be ignored; it is not stored for later use.
REQ-026 upd_immediate SHALL be sampled only in the last CONV cycle.
REQ-027 The displayed outputs SHALL hold their last committed value between commits, including while busy.
REQ-028 Latency with upd_immediate=1: handshake at edge N; outputs SHALL change at edge N+1+NBITS (N+15 with defaults).
REQ-029 Latency with upd_immediate=0: outputs SHALL change at the first edge in PEND where frame_rise=1.
REQ-030 val_valid while busy SHALL be ignored; the source holds val_valid until val_ready.

Reset
REQ-031 While rst_n=0 the block SHALL force:
- state=IDLE;
- znak=0;
- all cifra_* = 0;
- busy=0;
- vs_d=0;
- all shadow registers and the counter cleared.
REQ-032 val_ready SHALL be 1 while in reset.
REQ-033 Assertion of rst_n mid-conversion or during PEND SHALL discard the pending value; the first value after release SHALL convert normally.

Verification
REQ-034 val_in=1234, upd_immediate=1, handshake at edge 0 -> at edge 15: znak=0, digits 1,2,3,4; busy low after the commit.
REQ-035 val_in=-507, upd_immediate=0, vsync rises 40 cycles later -> outputs unchanged until the edge where frame_rise=1, then znak=1, digits 0,5,0,7.
REQ-036 val_in=12000, then val_in=-16384 -> both display 9,9,9,9; znak=0 for the first and 1 for the second.
REQ-037 val_in=0 -> znak=0, digits 0,0,0,0; also: vsync rise during CONV, upd_immediate=0 -> no commit until the next rise.
REQ-038 rst_n pulsed low at CONV iteration 7 of 4321 -> outputs 0 immediately, val_ready=1; a following 0042 commits 0,0,4,2.
REQ-039 val_valid held high through a busy period with a changing val_in -> only the value present at a val_ready=1 edge is captured.
